// File: rtl/relm_ps2_rx.sv
// PS/2 receive deserializer: glitch-filtered pad sampling, 11-bit frame checking,
// and a show-ahead byte FIFO exposed to the ReLM core as a single pop port.
module relm_ps2_rx #(
  parameter int unsigned WD      = 32,
  parameter int unsigned WAD     = 4,
  parameter int unsigned NFILT   = 8,
  parameter int unsigned WT      = 17,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  input  logic [WD:0]   pop_d,
  output logic [WD:0]   pop_q
);

  localparam int unsigned DEPTH = 2 ** WAD;
  localparam int unsigned WC    = WAD + 1;
  localparam logic [WT-1:0] TO_LAST = WT'(TIMEOUT - 1);
  localparam logic [WT-1:0] TO_MAX  = '1;
  localparam logic [WC-1:0] FULL_CNT = WC'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // Pad filters; the shift registers also serve as the synchronizer for the async pads.
  logic [NFILT-1:0] clk_sr;
  logic [NFILT-1:0] dat_sr;
  logic             clk_f;
  logic             dat_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr <= '1;
      dat_sr <= '1;
      clk_f  <= 1'b1;
      dat_f  <= 1'b1;
    end else begin
      clk_sr <= {clk_sr[NFILT-2:0], ps2_clk_in};
      dat_sr <= {dat_sr[NFILT-2:0], ps2_dat_in};
      if (&clk_sr)       clk_f <= 1'b1;
      else if (~|clk_sr) clk_f <= 1'b0;
      if (&dat_sr)       dat_f <= 1'b1;
      else if (~|dat_sr) dat_f <= 1'b0;
    end
  end

  // Falling edge: the cycle in which filtered clk is about to drop from 1 to 0.
  logic fall_c;
  assign fall_c = clk_f & ~|clk_sr;

  // Frame state
  state_t        state;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          par;
  logic [WT-1:0] tcnt;

  logic timeout_c;
  logic stop_c;
  logic frame_ok_c;
  logic frame_good_c;
  logic frame_bad_c;

  assign timeout_c    = (state != S_IDLE) && (tcnt == TO_LAST);
  assign stop_c       = fall_c && !timeout_c && (state == S_STOP);
  assign frame_ok_c   = dat_f && (^{sh, par});
  assign frame_good_c = stop_c && frame_ok_c;
  assign frame_bad_c  = timeout_c || (stop_c && !frame_ok_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bcnt  <= 3'd0;
      sh    <= 8'h00;
      par   <= 1'b0;
      tcnt  <= '0;
    end else begin
      if ((state == S_IDLE) || fall_c) tcnt <= '0;
      else if (tcnt != TO_MAX)         tcnt <= tcnt + WT'(1);

      if (timeout_c) begin
        state <= S_IDLE;
      end else if (fall_c) begin
        case (state)
          S_IDLE: begin
            // A high start bit is treated as line noise and ignored.
            if (!dat_f) begin
              state <= S_DATA;
              bcnt  <= 3'd0;
            end
          end
          S_DATA: begin
            sh <= {dat_f, sh[7:1]};
            if (bcnt == 3'd7) state <= S_PAR;
            else              bcnt  <= bcnt + 3'd1;
          end
          S_PAR: begin
            par   <= dat_f;
            state <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Show-ahead FIFO
  logic [7:0]     mem [DEPTH];
  logic [WAD-1:0] rd;
  logic [WAD-1:0] wr;
  logic [WC-1:0]  cnt;
  logic           err_q;
  logic           ovf_q;

  logic valid_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic ovf_set_c;
  logic clr_c;

  assign valid_c   = (cnt != '0);
  assign full_c    = (cnt == FULL_CNT);
  assign pop_c     = pop_d[WD] && valid_c;
  assign push_c    = frame_good_c && (!full_c || pop_c);
  assign ovf_set_c = frame_good_c && full_c && !pop_c;
  assign clr_c     = pop_d[WD] && pop_d[WD-2];

  always_ff @(posedge clk) begin
    if (push_c) mem[wr] <= sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (push_c) wr <= wr + WAD'(1);
      if (pop_c)  rd <= rd + WAD'(1);
      case ({push_c, pop_c})
        2'b10:   cnt <= cnt + WC'(1);
        2'b01:   cnt <= cnt - WC'(1);
        default: cnt <= cnt;
      endcase
      // Set has priority over a simultaneous clear.
      if (frame_bad_c)    err_q <= 1'b1;
      else if (clr_c)     err_q <= 1'b0;
      if (ovf_set_c)      ovf_q <= 1'b1;
      else if (clr_c)     ovf_q <= 1'b0;
    end
  end

  // Pop response; the byte field reads as zero whenever nothing is buffered.
  always_comb begin
    pop_q      = '0;
    pop_q[WD]  = !valid_c && !pop_d[WD-1];
    pop_q[10]  = err_q;
    pop_q[9]   = ovf_q;
    pop_q[8]   = valid_c;
    pop_q[7:0] = valid_c ? mem[rd] : 8'h00;
  end

  logic unused_pop_bits;
  assign unused_pop_bits = ^pop_d[WD-3:0];

endmodule

// File: tb/tb_relm_ps2_rx.sv
// Directed bench for relm_ps2_rx: drives PS/2 frames on the pads and checks pop responses.
`timescale 1ns/1ps
module tb_relm_ps2_rx;

  localparam int unsigned WD      = 32;
  localparam int unsigned WAD     = 4;
  localparam int unsigned NFILT   = 8;
  localparam int unsigned WT      = 17;
  localparam int unsigned TIMEOUT = 1000;

  localparam logic [WD:0] STB = 33'h1_0000_0000;
  localparam logic [WD:0] NB  = 33'h0_8000_0000;
  localparam logic [WD:0] CLR = 33'h0_4000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk_in = 1'b1;
  logic          ps2_dat_in = 1'b1;
  logic [WD:0]   pop_d = '0;
  logic [WD:0]   pop_q;

  int checks   = 0;
  int failures = 0;

  relm_ps2_rx #(
    .WD(WD), .WAD(WAD), .NFILT(NFILT), .WT(WT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .pop_d(pop_d),
    .pop_q(pop_q)
  );

  // 5 MHz system clock; a 20 us PS/2 bit is 100 clk cycles.
  always #100 clk = ~clk;

  task automatic chk(input string tag, input logic [WD:0] obs, input logic [WD:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop(input string tag, input logic [WD:0] req, input logic [WD:0] exp);
    @(negedge clk);
    pop_d = req;
    #1;
    chk(tag, pop_q, exp);
    @(posedge clk);
    #1;
    pop_d = '0;
  endtask

  // One bit: data set while clock high, 10 us low pulse, optional short clk glitch after.
  task automatic send_bit(input logic v, input logic glitch);
    ps2_dat_in = v;
    #5000;
    ps2_clk_in = 1'b0;
    #10000;
    ps2_clk_in = 1'b1;
    #2000;
    if (glitch) begin
      ps2_clk_in = 1'b0;
      #600;
      ps2_clk_in = 1'b1;
      #2400;
    end else begin
      #3000;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic glitch);
    logic p;
    p = (~^b) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(p, glitch);
    send_bit(1'b1, glitch);
    ps2_dat_in = 1'b1;
    #4000;
  endtask

  initial begin
    logic [7:0] part;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // Reset state
    pop("rst_idle", '0, STB);
    pop("rst_blk", STB, STB);
    pop("rst_nb", STB | NB, '0);

    // Clean frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b0);
    pop("good_1c", STB, 33'h11C);
    pop("good_1c_empty", STB | NB, '0);

    // Bad parity sets frame error, no data
    send_frame(8'h1C, 1'b1, 1'b0);
    pop("par_err", STB | NB, 33'h400);
    pop("par_err_clr", STB | NB | CLR, 33'h400);
    pop("par_err_after", STB | NB, '0);

    // Short clock glitches are filtered out
    send_frame(8'hF0, 1'b0, 1'b1);
    pop("glitch_f0", STB | NB, 33'h1F0);
    pop("glitch_empty", STB | NB, '0);

    // Abandoned frame times out, next frame still received
    part = 8'h15;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(part[i], 1'b0);
    ps2_dat_in = 1'b1;
    repeat (TIMEOUT + 10) @(posedge clk);
    send_frame(8'h5A, 1'b0, 1'b0);
    pop("timeout_5a", STB | CLR, 33'h55A);
    pop("timeout_empty", STB | NB, '0);

    // Overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) pop("ovf_pop", STB, 33'h300 + 33'(i));
    pop("ovf_last_clr", STB | CLR, 33'h30F);
    pop("ovf_drained", STB, STB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
